mat_loader: RTL and testbench

- Upstream feeder for the multiply2 matrix accelerator.
- Accepts a 32-bit valid/ready word stream and fills matrix A (first MAT_WORDS words), then matrix B (next MAT_WORDS words), holding both in local register banks wired to multiply2 mat_A/mat_B.
- Once both matrices are full, asserts start, waits for a done rising edge, pulses frame_done, then re-arms for the next frame.

---
 rtl/acc_pkg.sv | 18 +
 rtl/mat_bank.sv | 31 +++
 rtl/mat_loader.sv | 106 ++++++++++
 tb/tb_mat_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types for the matrix accelerator: bank word layout, default matrix
// size and the loader state encoding.
package acc_pkg;

  localparam int unsigned MAT_WORDS = 256;

  // Byte i of a stream word lands in word[i].
  typedef logic [3:0][7:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    RUN,
    FIN
  } ld_state_t;

endpackage

// File: rtl/mat_bank.sv
// MAT_WORDS x word_t register bank with a single write port and the whole
// array exposed as a read output.
module mat_bank
  import acc_pkg::*;
#(
  parameter int unsigned WORDS = MAT_WORDS,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  word_t            wdata_i,
  output word_t            bank_o [WORDS]
);

  word_t mem_q [WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign bank_o = mem_q;

endmodule

// File: rtl/mat_loader.sv
// Stream feeder for multiply2: fills bank A then bank B from a valid/ready
// word stream, starts the multiply and waits for a fresh done edge.
module mat_loader
  import acc_pkg::*;
#(
  parameter int unsigned MAT_WORDS = acc_pkg::MAT_WORDS,
  parameter int unsigned IDX_W     = $clog2(MAT_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output word_t            mat_A [MAT_WORDS],
  output word_t            mat_B [MAT_WORDS],
  output logic             mult_start,
  input  logic             mult_done,
  output logic             busy,
  output logic             frame_done,
  output logic [IDX_W-1:0] word_idx
);

  ld_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_q;
  logic             done_q;
  logic             hs;
  logic             last;
  logic             we_a, we_b;

  assign in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy       = (state_q == RUN);
  assign frame_done = (state_q == FIN);
  assign mult_start = start_q;
  assign word_idx   = idx_q;
  assign hs         = in_valid && in_ready;
  assign last       = (idx_q == IDX_W'(MAT_WORDS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_a    = 1'b0;
    we_b    = 1'b0;
    unique case (state_q)
      IDLE:   state_d = LOAD_A;
      LOAD_A: begin
        if (hs) begin
          we_a  = 1'b1;
          idx_d = idx_q + 1'b1;
          if (last) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (hs) begin
          we_b  = 1'b1;
          idx_d = idx_q + 1'b1;
          if (last) state_d = RUN;
        end
      end
      RUN:    if (mult_done && !done_q) state_d = FIN;
      FIN:    state_d = LOAD_A;
      default: state_d = IDLE;
    endcase
    // Abort wins over a same-cycle handshake: the word is dropped.
    if (clr && (state_q != IDLE)) begin
      state_d = LOAD_A;
      idx_d   = '0;
      we_a    = 1'b0;
      we_b    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= (state_d == RUN);
      done_q  <= mult_done;
    end
  end

  mat_bank #(.WORDS(MAT_WORDS), .IDX_W(IDX_W)) u_bank_a (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_a),
    .waddr_i (idx_q),
    .wdata_i (word_t'(in_data)),
    .bank_o  (mat_A)
  );

  mat_bank #(.WORDS(MAT_WORDS), .IDX_W(IDX_W)) u_bank_b (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_b),
    .waddr_i (idx_q),
    .wdata_i (word_t'(in_data)),
    .bank_o  (mat_B)
  );

endmodule

// File: tb/tb_mat_loader.sv
// Directed bench for mat_loader: vector table for the done/abort handshakes
// plus hand-written load, backpressure, abort and reset sequences.
`timescale 1ns/1ps
module tb_mat_loader;
  import acc_pkg::*;

  localparam int unsigned NW = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  word_t       mat_A [NW];
  word_t       mat_B [NW];
  logic        mult_start;
  logic        mult_done;
  logic        busy;
  logic        frame_done;
  logic [7:0]  word_idx;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mat_loader #(.MAT_WORDS(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mat_A      (mat_A),
    .mat_B      (mat_B),
    .mult_start (mult_start),
    .mult_done  (mult_done),
    .busy       (busy),
    .frame_done (frame_done),
    .word_idx   (word_idx)
  );

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        clr;
    logic        done;
    logic        rdy;
    logic        start;
    logic        busy;
    logic        fd;
    logic [7:0]  idx;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input logic [31:0] d0, input bit inc);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = inc ? d0 + 32'(i) : d0;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid  = tbl[i].valid;
      in_data   = tbl[i].data;
      clr       = tbl[i].clr;
      mult_done = tbl[i].done;
      step();
      chk($sformatf("v%0d_ready", i), 32'(in_ready),   32'(tbl[i].rdy));
      chk($sformatf("v%0d_start", i), 32'(mult_start), 32'(tbl[i].start));
      chk($sformatf("v%0d_busy", i),  32'(busy),       32'(tbl[i].busy));
      chk($sformatf("v%0d_fd", i),    32'(frame_done), 32'(tbl[i].fd));
      chk($sformatf("v%0d_idx", i),   32'(word_idx),   32'(tbl[i].idx));
    end
    clr      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int cyc;

    // RUN entered with done already high; only the later fresh edge completes.
    tbl[0] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    // Abort during RUN, then a done edge that must not produce frame_done.
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; mult_done = 1'b0;

    repeat (3) step();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_start", 32'(mult_start), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_fd",    32'(frame_done), 32'd0);
    chk("rst_idx",   32'(word_idx), 32'd0);
    chk("rst_A0",    mat_A[0], 32'd0);
    chk("rst_B255",  mat_B[255], 32'd0);
    rst = 1'b0;
    chk("idle_ready", 32'(in_ready), 32'd0);
    step();
    chk("loada_ready", 32'(in_ready), 32'd1);

    // Full frame
    stream(256, 32'h0202_0202, 1'b0);
    chk("ab_idx",   32'(word_idx), 32'd0);
    chk("ab_ready", 32'(in_ready), 32'd1);
    stream(255, 32'h0404_0404, 1'b0);
    chk("preB_start", 32'(mult_start), 32'd0);
    chk("preB_idx",   32'(word_idx), 32'd255);
    mult_done = 1'b1;
    stream(1, 32'h0404_0404, 1'b0);
    chk("run_start", 32'(mult_start), 32'd1);
    chk("run_ready", 32'(in_ready), 32'd0);
    chk("run_busy",  32'(busy), 32'd1);
    chk("run_idx",   32'(word_idx), 32'd0);
    chk("A0",   mat_A[0], 32'h0202_0202);
    chk("A255", mat_A[255], 32'h0202_0202);
    chk("B0",   mat_B[0], 32'h0404_0404);
    chk("B255", mat_B[255], 32'h0404_0404);
    chk("B255_byte3", 32'(mat_B[255][3]), 32'h04);

    run_vecs(0, 5);

    // Backpressure with garbage on invalid cycles
    cnt = 0;
    cyc = 0;
    while (cnt < 20 && cyc < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = in_valid ? (32'hA500_0000 | 32'(cnt)) : $urandom;
      step();
      if (in_valid) cnt++;
      cyc++;
      chk("bp_idx", 32'(word_idx), 32'(cnt));
    end
    in_valid = 1'b0;
    if (cnt < 20) begin
      nvec++;
      nfail++;
      $display("FAIL bp_budget: got %0d handshakes expected 20", cnt);
    end
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("bp_A%0d", k), mat_A[k], 32'hA500_0000 | 32'(k));
    end
    chk("bp_A20_kept", mat_A[20], 32'h0202_0202);

    // Abort in LOAD_B at index 100
    stream(236, 32'h0202_0202, 1'b0);
    stream(100, 32'hB000_0000, 1'b1);
    chk("pre_clr_idx", 32'(word_idx), 32'd100);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_idx",   32'(word_idx), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    chk("clr_B100",  mat_B[100], 32'h0404_0404);
    chk("clr_B99",   mat_B[99], 32'hB000_0063);
    stream(1, 32'h1111_1111, 1'b0);
    chk("clr_to_A0", mat_A[0], 32'h1111_1111);
    chk("clr_B0",    mat_B[0], 32'hB000_0000);
    chk("clr_idx1",  32'(word_idx), 32'd1);

    // Abort during RUN
    stream(255, 32'h3333_3333, 1'b0);
    stream(256, 32'hC000_0000, 1'b1);
    chk("run2_start", 32'(mult_start), 32'd1);
    chk("run2_B255",  mat_B[255], 32'hC000_00FF);
    run_vecs(6, 8);

    // Async reset between edges during RUN
    stream(256, 32'h5555_5555, 1'b0);
    stream(256, 32'h6666_6666, 1'b0);
    chk("run3_start", 32'(mult_start), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_start", 32'(mult_start), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_idx",   32'(word_idx), 32'd0);
    chk("arst_A0",    mat_A[0], 32'd0);
    chk("arst_B255",  mat_B[255], 32'd0);
    step();
    rst = 1'b0;
    chk("arst_idle_ready", 32'(in_ready), 32'd0);
    step();
    chk("arst_loada_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
